// File: rtl/wm8731_cfg_seq_pkg.sv
// Shared types and constants for the WM8731 configuration sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wm8731_cfg_seq_pkg;

    typedef enum logic [2:0] {
        ST_SETTLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GAP,
        ST_SERVE
    } state_t;

    localparam int         N_REGS   = 11;
    localparam logic [3:0] LAST_IDX = 4'(N_REGS - 1);

    // WM8731 register addresses (7-bit)
    localparam logic [6:0] REG_LLINE  = 7'h00;
    localparam logic [6:0] REG_RLINE  = 7'h01;
    localparam logic [6:0] REG_LHP    = 7'h02;
    localparam logic [6:0] REG_RHP    = 7'h03;
    localparam logic [6:0] REG_APATH  = 7'h04;
    localparam logic [6:0] REG_DPATH  = 7'h05;
    localparam logic [6:0] REG_PWR    = 7'h06;
    localparam logic [6:0] REG_IFACE  = 7'h07;
    localparam logic [6:0] REG_SRATE  = 7'h08;
    localparam logic [6:0] REG_ACTIVE = 7'h09;
    localparam logic [6:0] REG_RESET  = 7'h0F;

    // Codec control word: 7-bit register address above 9-bit register data.
    function automatic logic [15:0] mk_word(input logic [6:0] addr, input logic [8:0] data);
        return {addr, data};
    endfunction

endpackage

// File: rtl/wm8731_cfg_rom.sv
// Fixed WM8731 power-up register table, index to 16-bit control word.
// Latency: combinational.
// Backpressure: none; indexes past the table return zero.
module wm8731_cfg_rom
    import wm8731_cfg_seq_pkg::*;
(
    input  logic [3:0]  idx,
    output logic [15:0] word
);

    // Table lookup; order matters: the codec is reset first and activated last.
    always_comb begin
        word = 16'h0000;
        case (idx)
            4'd0:    word = mk_word(REG_RESET,  9'h000);
            4'd1:    word = mk_word(REG_LLINE,  9'h017);
            4'd2:    word = mk_word(REG_RLINE,  9'h017);
            4'd3:    word = mk_word(REG_LHP,    9'h079);
            4'd4:    word = mk_word(REG_RHP,    9'h079);
            4'd5:    word = mk_word(REG_APATH,  9'h012);
            4'd6:    word = mk_word(REG_DPATH,  9'h000);
            4'd7:    word = mk_word(REG_PWR,    9'h000);
            4'd8:    word = mk_word(REG_IFACE,  9'h002);
            4'd9:    word = mk_word(REG_SRATE,  9'h000);
            4'd10:   word = mk_word(REG_ACTIVE, 9'h001);
            default: word = 16'h0000;
        endcase
    end

endmodule

// File: rtl/wm8731_cfg_seq.sv
// Pushes the WM8731 register table into i2cc after reset, then arbitrates i2cc to host writes.
// Latency: first strobe SETTLE_CYCLES+1 cycles after reset; host_ack 2 cycles after host_req seen in SERVE.
// Backpressure: waits on i2c_idle before each strobe; host_req is held off until the table completes.
module wm8731_cfg_seq
    import wm8731_cfg_seq_pkg::*;
#(
    parameter logic [7:0] DEV_WR_BYTE   = 8'h34,
    parameter int         SETTLE_CYCLES = 1000,
    parameter int         GAP_CYCLES    = 64,
    parameter int         BUSY_TIMEOUT  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        restart,
    input  logic        host_req,
    input  logic [15:0] host_data,
    output logic        host_ack,
    output logic [23:0] i2c_din,
    output logic        i2c_wr,
    input  logic        i2c_idle,
    output logic        cfg_done,
    output logic [3:0]  cfg_index,
    output logic        cfg_err
);

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] GAP_LAST    = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] BUSY_LAST   = 16'(BUSY_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        host_mode_q, host_mode_d;
    logic        retry_q, retry_d;
    logic [23:0] din_q, din_d;
    logic        wr_q, wr_d;
    logic        ack_q, ack_d;
    logic        done_q, done_d;
    logic [3:0]  idx_q, idx_d;
    logic        err_q, err_d;
    logic [15:0] rom_word;

    wm8731_cfg_rom u_rom (
        .idx  (idx_q),
        .word (rom_word)
    );

    // Next-state logic: one frame per transaction, settle/gap timers share cnt.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        host_mode_d = host_mode_q;
        retry_d     = retry_q;
        din_d       = din_q;
        wr_d        = 1'b0;
        ack_d       = 1'b0;
        done_d      = done_q;
        idx_d       = idx_q;
        err_d       = err_q;
        case (state_q)
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_ISSUE: begin
                if (i2c_idle) begin
                    // A reissue resends the held frame; the host may already have moved on.
                    if (!retry_q) begin
                        din_d = {DEV_WR_BYTE, host_mode_q ? host_data : rom_word};
                    end
                    wr_d    = 1'b1;
                    ack_d   = host_mode_q && !retry_q;
                    cnt_d   = '0;
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (!i2c_idle) begin
                    retry_d = 1'b0;
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == BUSY_LAST) begin
                    err_d   = 1'b1;
                    retry_d = 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_WAIT_DONE: begin
                if (i2c_idle) begin
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (host_mode_q) begin
                        state_d = ST_SERVE;
                    end else if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = ST_SERVE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_ISSUE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_SERVE: begin
                // restart outranks a pending host write, which stays pending.
                if (restart) begin
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    idx_d       = '0;
                    cnt_d       = '0;
                    host_mode_d = 1'b0;
                    state_d     = ST_SETTLE;
                end else if (host_req) begin
                    host_mode_d = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            default: state_d = ST_SETTLE;
        endcase
    end

    // State and output registers; reset drops back to SETTLE from anywhere.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_SETTLE;
            cnt_q       <= '0;
            host_mode_q <= 1'b0;
            retry_q     <= 1'b0;
            din_q       <= '0;
            wr_q        <= 1'b0;
            ack_q       <= 1'b0;
            done_q      <= 1'b0;
            idx_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            host_mode_q <= host_mode_d;
            retry_q     <= retry_d;
            din_q       <= din_d;
            wr_q        <= wr_d;
            ack_q       <= ack_d;
            done_q      <= done_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
        end
    end

    assign i2c_din   = din_q;
    assign i2c_wr    = wr_q;
    assign host_ack  = ack_q;
    assign cfg_done  = done_q;
    assign cfg_index = idx_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_wm8731_cfg_seq.sv
// Bench for wm8731_cfg_seq with a behavioural i2cc model and frame scoreboard.
// Latency: n/a.
// Backpressure: model holds i2c_idle low for 40 cycles per accepted frame.
module tb_wm8731_cfg_seq;

    localparam int SETTLE   = 1000;
    localparam int GAP      = 64;
    localparam int BUSY_TO  = 4;
    localparam int BUSY_LEN = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        restart;
    logic        host_req;
    logic [15:0] host_data;
    logic        host_ack;
    logic [23:0] i2c_din;
    logic        i2c_wr;
    logic        i2c_idle;
    logic        cfg_done;
    logic [3:0]  cfg_index;
    logic        cfg_err;

    always #5 clk = ~clk;

    wm8731_cfg_seq #(
        .DEV_WR_BYTE   (8'h34),
        .SETTLE_CYCLES (SETTLE),
        .GAP_CYCLES    (GAP),
        .BUSY_TIMEOUT  (BUSY_TO)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .restart   (restart),
        .host_req  (host_req),
        .host_data (host_data),
        .host_ack  (host_ack),
        .i2c_din   (i2c_din),
        .i2c_wr    (i2c_wr),
        .i2c_idle  (i2c_idle),
        .cfg_done  (cfg_done),
        .cfg_index (cfg_index),
        .cfg_err   (cfg_err)
    );

    int errors      = 0;
    int checks      = 0;
    int cyc         = 0;
    int wr_count    = 0;
    int ack_count   = 0;
    int last_wr_cyc = 0;
    int busy_cnt    = 0;
    int rel_cyc     = 0;
    int done_cyc    = 0;
    logic [23:0] exp_q[$];
    logic [23:0] sb_exp;
    logic [23:0] txn_din = '0;
    bit          stuck_arm = 1'b0;
    logic [23:0] stuck_din = '0;
    logic [15:0] rom_words [0:10] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                                      16'h0812, 16'h0A00, 16'h0C00, 16'h0E02, 16'h1000, 16'h1201};

    // i2cc model plus scoreboard, stepping 1 time unit after each rising edge.
    initial begin
        i2c_idle = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst_n !== 1'b1) begin
                i2c_idle = 1'b1;
                busy_cnt = 0;
            end else begin
                if (busy_cnt > 0) begin
                    checks++;
                    if (i2c_din !== txn_din) begin
                        errors++;
                        $display("FAIL din_stable cyc=%0d got %h want %h", cyc, i2c_din, txn_din);
                    end
                    busy_cnt--;
                    if (busy_cnt == 0) i2c_idle = 1'b1;
                end
                if (i2c_wr === 1'b1) begin
                    wr_count++;
                    last_wr_cyc = cyc;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_wr cyc=%0d din=%h", cyc, i2c_din);
                    end else begin
                        sb_exp = exp_q.pop_front();
                        if (i2c_din !== sb_exp) begin
                            errors++;
                            $display("FAIL frame cyc=%0d got %h want %h", cyc, i2c_din, sb_exp);
                        end
                    end
                    if (stuck_arm && i2c_din === stuck_din) begin
                        stuck_arm = 1'b0;
                    end else begin
                        i2c_idle = 1'b0;
                        busy_cnt = BUSY_LEN;
                        txn_din  = i2c_din;
                    end
                end
                if (host_ack === 1'b1) begin
                    ack_count++;
                    checks++;
                    if (i2c_wr !== 1'b1) begin
                        errors++;
                        $display("FAIL ack_without_wr cyc=%0d wr=%b want 1", cyc, i2c_wr);
                    end
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_wrs(input int n, input int budget, output bit ok);
        int target;
        target = wr_count + n;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (wr_count >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (cfg_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic push_table(input bit dup_idx2);
        for (int i = 0; i < 11; i++) begin
            exp_q.push_back({8'h34, rom_words[i]});
            if (dup_idx2 && i == 2) exp_q.push_back({8'h34, rom_words[i]});
        end
    endtask

    task automatic test_reset();
        restart   = 1'b0;
        host_req  = 1'b0;
        host_data = '0;
        rst_n     = 1'b1;
        #3;
        rst_n = 1'b0;
        repeat (3) tick();
        checks += 6;
        if (i2c_wr !== 1'b0)    begin errors++; $display("FAIL rst_wr got %b want 0", i2c_wr); end
        if (i2c_din !== 24'h0)  begin errors++; $display("FAIL rst_din got %h want 0", i2c_din); end
        if (host_ack !== 1'b0)  begin errors++; $display("FAIL rst_ack got %b want 0", host_ack); end
        if (cfg_done !== 1'b0)  begin errors++; $display("FAIL rst_done got %b want 0", cfg_done); end
        if (cfg_index !== 4'd0) begin errors++; $display("FAIL rst_index got %0d want 0", cfg_index); end
        if (cfg_err !== 1'b0)   begin errors++; $display("FAIL rst_err got %b want 0", cfg_err); end
        rst_n   = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic test_table();
        bit ok;
        int prev;
        push_table(1'b0);
        wait_wrs(1, SETTLE + 50, ok);
        checks++;
        if (!ok || cyc - rel_cyc != SETTLE + 1) begin
            errors++;
            $display("FAIL first_wr_latency got %0d want %0d", cyc - rel_cyc, SETTLE + 1);
        end
        for (int k = 1; k <= 10; k++) begin
            prev = last_wr_cyc;
            if (k == 3) begin
                restart = 1'b1;
                tick();
                restart = 1'b0;
            end
            if (k == 5) begin
                host_data = 16'h0579;
                host_req  = 1'b1;
                exp_q.push_back(24'h340579);
            end
            wait_wrs(1, 300, ok);
            checks++;
            if (!ok || last_wr_cyc - prev != 42 + GAP) begin
                errors++;
                $display("FAIL wr_spacing k=%0d got %0d want %0d", k, last_wr_cyc - prev, 42 + GAP);
            end
        end
        checks++;
        if (i2c_din !== 24'h341201) begin
            errors++;
            $display("FAIL last_frame got %h want 341201", i2c_din);
        end
        wait_done(300, ok);
        done_cyc = cyc;
        checks += 3;
        if (!ok || cyc - last_wr_cyc != 41 + GAP) begin
            errors++;
            $display("FAIL done_timing got %0d want %0d", cyc - last_wr_cyc, 41 + GAP);
        end
        if (cfg_index !== 4'd10) begin
            errors++;
            $display("FAIL done_index got %0d want 10", cfg_index);
        end
        if (ack_count != 0) begin
            errors++;
            $display("FAIL host_holdoff acks=%0d want 0", ack_count);
        end
    endtask

    task automatic test_host();
        bit ok;
        int a0;
        int w0;
        a0 = ack_count;
        wait_wrs(1, 100, ok);
        w0 = wr_count;
        checks += 2;
        if (!ok || cyc - done_cyc != 2) begin
            errors++;
            $display("FAIL host_latency got %0d want 2", cyc - done_cyc);
        end
        if (host_ack !== 1'b1) begin
            errors++;
            $display("FAIL host_ack got %b want 1", host_ack);
        end
        host_req = 1'b0;
        repeat (200) tick();
        checks += 2;
        if (wr_count != w0) begin
            errors++;
            $display("FAIL host_single_wr extra=%0d want 0", wr_count - w0);
        end
        if (ack_count != a0 + 1) begin
            errors++;
            $display("FAIL host_ack_count got %0d want %0d", ack_count, a0 + 1);
        end
    endtask

    task automatic test_busy_timeout();
        bit ok;
        int w3;
        stuck_din = 24'h340217;
        stuck_arm = 1'b1;
        push_table(1'b1);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        checks += 2;
        if (cfg_done !== 1'b0)  begin errors++; $display("FAIL restart_done got %b want 0", cfg_done); end
        if (cfg_index !== 4'd0) begin errors++; $display("FAIL restart_index got %0d want 0", cfg_index); end
        wait_wrs(3, SETTLE + 500, ok);
        w3 = last_wr_cyc;
        checks += 2;
        if (!ok) begin errors++; $display("FAIL timeout_reach_frame3 got 0 want 1"); end
        if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_before_timeout got %b want 0", cfg_err); end
        wait_wrs(1, 20, ok);
        checks += 2;
        if (!ok || last_wr_cyc - w3 != BUSY_TO + 1) begin
            errors++;
            $display("FAIL reissue_delay got %0d want %0d", last_wr_cyc - w3, BUSY_TO + 1);
        end
        if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", cfg_err); end
        wait_done(11 * 200, ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL timeout_seq_done got 0 want 1"); end
        if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", cfg_err); end
    endtask

    task automatic test_restart_vs_host();
        bit ok;
        int a0;
        a0 = ack_count;
        host_data = 16'h0579;
        host_req  = 1'b1;
        restart   = 1'b1;
        push_table(1'b0);
        exp_q.push_back(24'h340579);
        tick();
        restart = 1'b0;
        checks += 3;
        if (cfg_done !== 1'b0) begin errors++; $display("FAIL rvh_done got %b want 0", cfg_done); end
        if (cfg_err !== 1'b0)  begin errors++; $display("FAIL rvh_err got %b want 0", cfg_err); end
        if (host_ack !== 1'b0) begin errors++; $display("FAIL rvh_ack got %b want 0", host_ack); end
        wait_done(SETTLE + 11 * 120, ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL rvh_table_done got 0 want 1"); end
        if (ack_count != a0) begin errors++; $display("FAIL rvh_early_ack got %0d want %0d", ack_count, a0); end
        wait_wrs(1, 100, ok);
        checks += 2;
        if (!ok || host_ack !== 1'b1) begin
            errors++;
            $display("FAIL rvh_host_served ack=%b want 1", host_ack);
        end
        host_req = 1'b0;
        if (ack_count != a0 + 1) begin
            errors++;
            $display("FAIL rvh_ack_count got %0d want %0d", ack_count, a0 + 1);
        end
        repeat (150) tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        for (int i = 0; i < 5; i++) exp_q.push_back({8'h34, rom_words[i]});
        wait_wrs(5, SETTLE + 700, ok);
        repeat (10) tick();
        checks += 2;
        if (!ok) begin errors++; $display("FAIL mid_reach_frame5 got 0 want 1"); end
        if (cfg_index !== 4'd4) begin errors++; $display("FAIL mid_index got %0d want 4", cfg_index); end
        rst_n = 1'b0;
        #1;
        checks += 6;
        if (i2c_wr !== 1'b0)    begin errors++; $display("FAIL mid_rst_wr got %b want 0", i2c_wr); end
        if (i2c_din !== 24'h0)  begin errors++; $display("FAIL mid_rst_din got %h want 0", i2c_din); end
        if (host_ack !== 1'b0)  begin errors++; $display("FAIL mid_rst_ack got %b want 0", host_ack); end
        if (cfg_done !== 1'b0)  begin errors++; $display("FAIL mid_rst_done got %b want 0", cfg_done); end
        if (cfg_index !== 4'd0) begin errors++; $display("FAIL mid_rst_index got %0d want 0", cfg_index); end
        if (cfg_err !== 1'b0)   begin errors++; $display("FAIL mid_rst_err got %b want 0", cfg_err); end
        repeat (3) tick();
        rst_n   = 1'b1;
        rel_cyc = cyc;
        exp_q.push_back(24'h341E00);
        wait_wrs(1, SETTLE + 50, ok);
        checks++;
        if (!ok || cyc - rel_cyc != SETTLE + 1) begin
            errors++;
            $display("FAIL mid_restart_latency got %0d want %0d", cyc - rel_cyc, SETTLE + 1);
        end
    endtask

    initial begin
        test_reset();
        test_table();
        test_host();
        test_busy_timeout();
        test_restart_vs_host();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL frames_outstanding got %0d want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
